// File: rtl/sd_cmd_sequencer_if.sv
// Request/status and register-bus bundle between the audio logic, the
// sd_cmd_sequencer and the sdc_controller register port.
interface sd_cmd_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              init_mode;
    logic [15:0]       rca;
    logic [15:0]       blk_addr;
    logic [CNT_W-1:0]  blk_count;
    logic              cmd_done;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              bus_we;

    // master: the sequencer, which drives the controller register bus
    modport master (
        input  start, init_mode, rca, blk_addr, blk_count, cmd_done,
        output busy, done, error, bus_addr, bus_data, bus_we
    );

    modport slave (
        output start, init_mode, rca, blk_addr, blk_count, cmd_done,
        input  busy, done, error, bus_addr, bus_data, bus_we
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Autonomous sdc_controller register-bus master: optional CMD0/CMD7 card init,
// then N CMD17 single-block reads at incrementing block addresses.
module sd_cmd_sequencer #(
    parameter int         ADDR_W     = 7,
    parameter int         DATA_W     = 8,
    parameter int         CNT_W      = 8,
    parameter int         TIMEOUT    = 4096,
    parameter int         INIT_GAP   = 500,
    parameter logic [7:0] READ_FLAGS = 8'b0111_1101
) (
    input logic                clk,
    input logic                rst,
    sd_cmd_sequencer_if.master bus
);
    localparam int MAXC = (TIMEOUT > INIT_GAP) ? TIMEOUT : INIT_GAP;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE, CMD0_WR, CMD0_GAP, CMD7_WR, BLK_WR, WAIT, NEXT, FIN
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       rca_q, rca_d;
    logic [15:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        widx_q, widx_d;
    logic              ph_q, ph_d;
    logic              wait7_q, wait7_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_act, wr_last, wr_step;

    // Register-write tables for the three write bursts, indexed by write number
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        wr_act  = 1'b0;
        wr_last = 1'b0;
        case (state_q)
            CMD0_WR: begin
                wr_act  = 1'b1;
                wr_last = (widx_q == 3'd1);
                if (widx_q == 3'd0) begin
                    wr_addr = ADDR_W'(5);
                    wr_data = DATA_W'(0);
                end
            end
            CMD7_WR: begin
                wr_act  = 1'b1;
                wr_last = (widx_q == 3'd3);
                case (widx_q)
                    3'd0:    begin wr_addr = ADDR_W'(5); wr_data = DATA_W'(7);      end
                    3'd1:    begin wr_addr = ADDR_W'(4); wr_data = rca_q[15:8];     end
                    3'd2:    begin wr_addr = ADDR_W'(3); wr_data = rca_q[7:0];      end
                    default: begin wr_addr = ADDR_W'(0); wr_data = DATA_W'(0);      end
                endcase
            end
            BLK_WR: begin
                wr_act  = 1'b1;
                wr_last = (widx_q == 3'd5);
                case (widx_q)
                    3'd0:    begin wr_addr = ADDR_W'(8'h48); wr_data = DATA_W'(0);  end
                    3'd1:    begin wr_addr = ADDR_W'(5);     wr_data = DATA_W'(17); end
                    3'd2:    begin wr_addr = ADDR_W'(4);     wr_data = READ_FLAGS;  end
                    3'd3:    begin wr_addr = ADDR_W'(3);     wr_data = addr_q[15:8]; end
                    3'd4:    begin wr_addr = ADDR_W'(2);     wr_data = addr_q[7:0];  end
                    default: begin wr_addr = ADDR_W'(0);     wr_data = DATA_W'(0);  end
                endcase
            end
            default: ;
        endcase
    end

    // Each write takes two cycles: setup (we=0), then strobe (we=1)
    assign wr_step = wr_act & ph_q;

    always_comb begin
        state_d     = state_q;
        rca_d       = rca_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        ph_d        = ph_q;
        wait7_d     = wait7_q;
        err_d       = err_q;
        last_addr_d = wr_act ? wr_addr : last_addr_q;
        last_data_d = wr_act ? wr_data : last_data_q;

        if (wr_act) begin
            ph_d = ~ph_q;
            if (ph_q) widx_d = wr_last ? 3'd0 : widx_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d  = 1'b0;
                    rca_d  = bus.rca;
                    addr_d = bus.blk_addr;
                    rem_d  = bus.blk_count;
                    widx_d = 3'd0;
                    ph_d   = 1'b0;
                    cnt_d  = '0;
                    if (bus.init_mode)               state_d = CMD0_WR;
                    else if (bus.blk_count == '0)    state_d = FIN;
                    else                             state_d = BLK_WR;
                end
            end
            CMD0_WR: if (wr_step && wr_last) begin
                state_d = CMD0_GAP;
                cnt_d   = '0;
            end
            // CMD0 has no response; the card just needs time to settle
            CMD0_GAP: begin
                if (cnt_q == CW'(INIT_GAP - 1)) begin
                    state_d = CMD7_WR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CMD7_WR: if (wr_step && wr_last) begin
                state_d = WAIT;
                wait7_d = 1'b1;
                cnt_d   = '0;
            end
            BLK_WR: if (wr_step && wr_last) begin
                state_d = WAIT;
                wait7_d = 1'b0;
                cnt_d   = '0;
            end
            // cmd_done wins over a timeout landing in the same cycle
            WAIT: begin
                if (bus.cmd_done) begin
                    if (!wait7_q)          state_d = NEXT;
                    else if (rem_q == '0)  state_d = FIN;
                    else                   state_d = BLK_WR;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NEXT: begin
                addr_d  = addr_q + 16'd1;
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q != CNT_W'(1)) ? BLK_WR : FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rca_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            widx_q      <= '0;
            ph_q        <= 1'b0;
            wait7_q     <= 1'b0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rca_q       <= rca_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            ph_q        <= ph_d;
            wait7_q     <= wait7_d;
            err_q       <= err_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    assign bus.busy     = (state_q != IDLE) && (state_q != FIN);
    assign bus.done     = (state_q == FIN);
    assign bus.error    = err_q;
    assign bus.bus_addr = wr_act ? wr_addr : last_addr_q;
    assign bus.bus_data = wr_act ? wr_data : last_data_q;
    assign bus.bus_we   = wr_step;
endmodule
